// File: rtl/bus_uart_tx_if.sv
// CPU-side register bus plus serial/interrupt outputs of the UART transmitter.
interface bus_uart_tx_if;
  logic        bus_re;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        uart_txd;
  logic        irq_empty;

  modport master (
    output bus_re, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, uart_txd, irq_empty
  );

  modport slave (
    input  bus_re, bus_we, bus_addr, bus_wdata,
    output bus_rdata, uart_txd, irq_empty
  );
endinterface

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO; reads are zero-latency, writes land on the clock edge.
// No backpressure: a push into a full FIFO (without a same-cycle pop) is dropped and flags sticky overflow.
module bus_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic         clk,
  input  logic         rst,
  bus_uart_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [4:0]    r_count;
  logic          r_ovf;
  logic [15:0]   r_bauddiv;
  logic [15:0]   r_div;
  logic [15:0]   r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;

  logic        w_sel;
  logic [1:0]  w_off;
  logic        w_empty;
  logic        w_full;
  logic        w_busy;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic        w_baud_tc;
  logic        w_txd;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_sel      = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off      = bus.bus_addr[3:2];
  assign w_empty    = (r_count == 5'd0);
  assign w_full     = (r_count == 5'(FIFO_DEPTH));
  assign w_busy     = (r_state != IDLE);
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign w_push_req = w_sel && (w_off == 2'd0) && bus.bus_we[0];
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && !w_push;
  assign w_ovf_clr  = w_sel && (w_off == 2'd1) && bus.bus_we[0] && bus.bus_wdata[3];
  assign w_baud_tc  = (r_baud_cnt == r_div - 16'd1);
  assign w_status   = {23'b0, r_count, r_ovf, w_busy, w_full, w_empty};
  assign w_unused   = ^{bus.bus_addr[1:0], bus.bus_wdata[31:16], bus.bus_we[3:2]};

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= bus.bus_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_bauddiv <= DEFAULT_DIV;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if (w_sel && (w_off == 2'd2)) begin
        if (bus.bus_we[0]) r_bauddiv[7:0]  <= bus.bus_wdata[7:0];
        if (bus.bus_we[1]) r_bauddiv[15:8] <= bus.bus_wdata[15:8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_txd       = 1'b1;
    case (r_state)
      IDLE:  if (!w_empty) w_state_nxt = START;
      START: begin
        w_txd = 1'b0;
        if (w_baud_tc) w_state_nxt = DATA;
      end
      DATA: begin
        w_txd = r_shift[0];
        if (w_baud_tc && (r_bit_cnt == 3'd7)) w_state_nxt = STOP;
      end
      STOP:    if (w_baud_tc) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Divider is sampled once per frame so BAUDDIV writes only take effect on the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_div      <= 16'd1;
    end else if (w_pop) begin
      r_shift    <= r_fifo[r_rd_ptr];
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_div      <= (r_bauddiv == 16'd0) ? 16'd1 : r_bauddiv;
    end else if (w_busy) begin
      r_baud_cnt <= w_baud_tc ? 16'd0 : r_baud_cnt + 16'd1;
      if (w_baud_tc && (r_state == DATA)) begin
        r_shift   <= r_shift >> 1;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.bus_re && w_sel) begin
      case (w_off)
        2'd1:    w_rdata = w_status;
        2'd2:    w_rdata = {16'b0, r_bauddiv};
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.bus_rdata = w_rdata;
  assign bus.uart_txd  = w_txd;
  assign bus.irq_empty = w_empty && !w_busy;
endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench: stimulus queues expected frames/read data, monitors decode the line and bus and compare.
module tb_bus_uart_tx;
  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct {
    logic [7:0] b;
    int         div;
  } frame_t;

  typedef struct {
    logic [31:0] v;
    int          id;
  } rexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_uart_tx_if bif ();

  bus_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd868)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  frame_t fq[$];
  rexp_t  rq[$];
  int     checks = 0;
  int     errors = 0;
  int     rid    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    bif.bus_addr  = addr;
    bif.bus_wdata = data;
    bif.bus_we    = we;
    @(posedge clk);
    #1;
    bif.bus_we = 4'h0;
  endtask

  task automatic tx(input logic [7:0] b, input int div);
    frame_t f;
    f.b   = b;
    f.div = div;
    fq.push_back(f);
    wr(BASE, {24'h0, b}, 4'h1);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    rexp_t e;
    e.v  = exp;
    e.id = rid;
    rid++;
    rq.push_back(e);
    bif.bus_addr = addr;
    bif.bus_re   = 1'b1;
    @(posedge clk);
    #1;
    bif.bus_re = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      if (bif.irq_empty === 1'b1) break;
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout irq_empty still low after %0d cycles", name, n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : rd_mon
    rexp_t e;
    forever begin
      @(negedge clk);
      if (bif.bus_re === 1'b1) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected got=%h exp=none", bif.bus_rdata);
        end else begin
          e = rq.pop_front();
          check($sformatf("rd%0d", e.id), bif.bus_rdata, e.v);
        end
      end
    end
  end

  // Samples every cycle of a frame: start, 8 data bits LSB first, stop, then one idle-high cycle.
  initial begin : tx_mon
    frame_t      f;
    int          bad;
    bit          abort;
    logic [10:0] bits;
    int          bit_i;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && bif.uart_txd === 1'b0) begin
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame txd=0 with no byte queued");
          while (bif.uart_txd !== 1'b1) @(negedge clk);
        end else begin
          f     = fq.pop_front();
          bits  = {2'b11, f.b, 1'b0};
          bad   = 0;
          abort = 1'b0;
          for (int k = 0; k < 10 * f.div + 1 && !abort; k++) begin
            if (k != 0) @(negedge clk);
            if (rst === 1'b1) begin
              abort = 1'b1;
            end else begin
              bit_i = k / f.div;
              if (bif.uart_txd !== bits[bit_i]) bad++;
            end
          end
          if (!abort) begin
            checks++;
            if (bad != 0) begin
              errors++;
              $display("FAIL frame byte=%h div=%0d bad_samples=%0d want=0", f.b, f.div, bad);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    bif.bus_re    = 1'b0;
    bif.bus_we    = 4'h0;
    bif.bus_addr  = 32'h0;
    bif.bus_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", 32'(bif.uart_txd), 32'd1);
    check("rst_irq", 32'(bif.irq_empty), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Register map, decode and address aliasing
    rd(BASE + 32'h8, 32'h364);
    rd(BASE + 32'h4, 32'h1);
    rd(BASE + 32'hC, 32'h0);
    wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    wr(BASE + 32'h10, 32'hAB, 4'hF);
    wr(BASE + 32'h18, 32'h5, 4'hF);
    rd(BASE + 32'h10, 32'h0);
    rd(BASE + 32'hA, 32'h364);
    rd(BASE + 32'h4, 32'h1);
    bif.bus_addr = BASE + 32'h8;
    #1;
    check("rdata_re_low", bif.bus_rdata, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    check("idle_irq", 32'(bif.irq_empty), 32'd1);

    // 0x55 at div 4; irq_empty low covers the pop cycle plus 40 busy cycles
    wr(BASE + 32'h8, 32'd4, 4'b0011);
    tx(8'h55, 4);
    wait_idle("f55", 500, n);
    check("irq_low_cycles", 32'(n), 32'd41);
    check("irq_after_55", 32'(bif.irq_empty), 32'd1);

    // div 0 behaves as 1
    wr(BASE + 32'h8, 32'd0, 4'b0011);
    tx(8'hA3, 1);
    rd(BASE + 32'h4, 32'h10);
    rd(BASE + 32'h4, 32'h5);
    wait_idle("fA3", 500, n);
    rd(BASE + 32'h4, 32'h1);

    // Fill to full, overflow, W1C clear, then push into full FIFO on a pop cycle
    wr(BASE + 32'h8, 32'd2, 4'b0011);
    for (int k = 1; k <= 9; k++) tx(8'(k), 2);
    wr(BASE, 32'h0A, 4'h1);
    rd(BASE + 32'h4, 32'h8E);
    wr(BASE + 32'h4, 32'h8, 4'h1);
    rd(BASE + 32'h4, 32'h86);
    repeat (9) @(posedge clk);
    #1;
    tx(8'h77, 2);
    rd(BASE + 32'h4, 32'h86);
    wait_idle("fill", 3000, n);
    rd(BASE + 32'h4, 32'h1);

    // Mid-frame divider change applies to the next frame only
    wr(BASE + 32'h8, 32'd4, 4'b0011);
    tx(8'hC3, 4);
    tx(8'h3C, 8);
    repeat (10) @(posedge clk);
    #1;
    wr(BASE + 32'h8, 32'd8, 4'b0011);
    rd(BASE + 32'h8, 32'h8);
    wait_idle("div_change", 2000, n);

    // Reset during data bit 3 of 0x11 with three bytes queued
    wr(BASE + 32'h8, 32'd2, 4'b0011);
    tx(8'h11, 2);
    tx(8'h22, 2);
    tx(8'h33, 2);
    tx(8'h44, 2);
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_txd_bit3", 32'(bif.uart_txd), 32'd0);
    rst = 1'b1;
    fq.delete();
    #1;
    check("rst_mid_txd", 32'(bif.uart_txd), 32'd1);
    check("rst_mid_irq", 32'(bif.irq_empty), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd(BASE + 32'h4, 32'h1);
    rd(BASE + 32'h8, 32'h364);
    repeat (100) @(posedge clk);
    #1;
    check("post_rst_txd", 32'(bif.uart_txd), 32'd1);
    check("post_rst_irq", 32'(bif.irq_empty), 32'd1);

    check("frames_left", 32'(fq.size()), 32'd0);
    check("reads_left", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_uart_tx.md
BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, byte address of register block (16-byte aligned).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, 2..16).
REQ-003 SHALL have parameter DEFAULT_DIV, default 16'd868, reset value of BAUDDIV in clk cycles per bit.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port bus_re  input  1  read strobe from CPU memory stage.
REQ-007 SHALL have port bus_we  input  4  per-byte write enables, bit n = byte lane n.
REQ-008 SHALL have port bus_addr  input  32  byte address.
REQ-009 SHALL have port bus_wdata  input  32  write data.
REQ-010 SHALL have port bus_rdata  output  32  read data, combinational.
REQ-011 SHALL have port uart_txd  output  1  serial line, idle high.
REQ-012 SHALL have port irq_empty  output  1  high when FIFO empty and shifter idle.

Function
REQ-013 Block selected SHALL mean bus_addr[31:4] == BASE_ADDR[31:4]; offset = bus_addr[3:2]; bus_addr[1:0] ignored.
REQ-014 Register map SHALL be: 0 TXDATA (W), 1 STATUS (R/W1C), 2 BAUDDIV (R/W), 3 reserved (reads 0, writes ignored).
REQ-015 bus_rdata SHALL be 0 when not selected or bus_re low; else register value in the same cycle (zero-latency, single-cycle core).
REQ-016 STATUS read SHALL be {23'b0, count[4:0], ovf, busy, full, empty} at bits [8:4],3,2,1,0; count = FIFO occupancy.
REQ-017 Write to TXDATA with bus_we[0]=1 SHALL push bus_wdata[7:0] at the clock edge; other lanes ignored.
REQ-018 Push while full SHALL be dropped and set sticky ovf; FIFO contents unchanged.
REQ-019 Write to STATUS with bus_we[0]=1 and bus_wdata[3]=1 SHALL clear ovf; a same-cycle overflow event SHALL win (ovf stays 1).
REQ-020 BAUDDIV SHALL be 16 bits; bus_we[0] writes [7:0], bus_we[1] writes [15:8]; reads zero-extended.
REQ-021 Effective divider SHALL be max(BAUDDIV,1), latched at frame start; BAUDDIV writes mid-frame affect next frame only.
REQ-022 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-023 IDLE: uart_txd=1; if FIFO non-empty, pop head into shift register, load bit counter 0, baud counter 0, go START next cycle.
REQ-024 START: uart_txd=0 for exactly div cycles, then DATA.
REQ-025 DATA: uart_txd = shift[0], LSB first, each bit div cycles; after bit 7 go STOP.
REQ-026 STOP: uart_txd=1 for div cycles; then IDLE, and if FIFO non-empty, START begins the following cycle (1 idle cycle between frames).
REQ-027 Baud counter SHALL count 0..div-1 and wrap; bit advance on terminal count.
REQ-028 Simultaneous push and pop SHALL both occur; push while full with same-cycle pop SHALL be accepted (no ovf).
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-030 busy SHALL be 1 in START, DATA, STOP; irq_empty = empty & ~busy.
REQ-031 Reads SHALL have no side effects; bus_re and bus_we both active SHALL perform both.

Reset
REQ-032 rst high SHALL asynchronously force: state IDLE, uart_txd=1, FIFO empty (pointers and count 0), ovf=0, BAUDDIV=DEFAULT_DIV, counters 0, irq_empty=1.
REQ-033 rst asserted mid-frame SHALL abort the frame immediately; uart_txd returns high without glitch to 0; queued bytes discarded.
REQ-034 First frame after rst deassertion SHALL start only on a push.

Verification
REQ-035 BAUDDIV=4, write TXDATA=0x55 -> txd low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles; busy high 40 cycles; irq_empty rises after.
REQ-036 BAUDDIV=2, write 10 bytes back-to-back without draining -> first popped, next 8 queued, 10th sets ovf; STATUS reads count=8, full=1, ovf=1; write STATUS 0x8 -> ovf=0.
REQ-037 BAUDDIV=0 -> each bit lasts 1 cycle; 0xA3 transmits as 0,1,1,0,0,0,1,0,1,1 over 10 cycles.
REQ-038 Write BAUDDIV=8 during DATA of frame with div=4 -> current frame keeps 4-cycle bits, next frame uses 8.
REQ-039 Assert rst during DATA bit 3 with 3 bytes queued -> txd=1 same cycle, STATUS reads 0x1 after release, no further frames.
REQ-040 bus_addr=BASE_ADDR+0x10 read/write -> bus_rdata=0, no state change; read of BAUDDIV after reset -> 0x364.
